// File: rtl/set_assoc_wb_cache.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU
// replacement, a valid/ready core port and a block-wide memory port.
module set_assoc_wb_cache #(
  parameter int BLOCK_SIZE = 256,
  parameter int NUM_BLOCKS = 16,
  parameter int NUM_WAYS   = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cpu_v_i,
  input  logic                  cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [31:0]           cpu_wdata_i,
  output logic                  cpu_ready_o,
  output logic                  cpu_v_o,
  output logic [31:0]           cpu_rdata_o,
  output logic                  cpu_hit_o,
  output logic                  mem_v_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [BLOCK_SIZE-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_v_i,
  input  logic [BLOCK_SIZE-1:0] mem_rdata_i
);
  localparam int NUM_SETS    = NUM_BLOCKS / NUM_WAYS;
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE / 8);
  localparam int INDEX_BITS  = $clog2(NUM_SETS);
  localparam int TAG_BITS    = 32 - OFFSET_BITS - INDEX_BITS;
  localparam int WORDS       = BLOCK_SIZE / 32;
  localparam int WAY_BITS    = $clog2(NUM_WAYS);
  localparam int WSEL_BITS   = $clog2(WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_FILL_REQ, S_FILL_WAIT, S_RESPOND
  } state_e;

  state_e state_q, state_d;

  logic                  valid_q [NUM_SETS][NUM_WAYS];
  logic                  dirty_q [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0]   tag_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0]   age_q   [NUM_SETS][NUM_WAYS];
  logic [BLOCK_SIZE-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic                  req_we_q;
  logic [31:2]           req_addr_q;
  logic [31:0]           req_wdata_q;
  logic [WAY_BITS-1:0]   way_q;
  logic                  hit_q;
  logic [31:0]           rdata_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [WSEL_BITS-1:0]  wsel;
  logic                  hit, found_inv;
  logic [WAY_BITS-1:0]   hit_way, vic_way;
  logic                  blk_we, lru_en;
  logic [WAY_BITS-1:0]   blk_way, lru_way;
  logic [BLOCK_SIZE-1:0] blk_new;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr_i[1:0];
  assign idx  = req_addr_q[OFFSET_BITS +: INDEX_BITS];
  assign tag  = req_addr_q[31 -: TAG_BITS];
  assign wsel = req_addr_q[OFFSET_BITS-1:2];

  // Victim: lowest-index invalid way, otherwise the oldest (age NUM_WAYS-1).
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    vic_way   = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!found_inv && !valid_q[idx][w]) begin
        found_inv = 1'b1;
        vic_way   = WAY_BITS'(w);
      end
    end
    if (!found_inv) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (age_q[idx][w] == WAY_BITS'(NUM_WAYS - 1)) vic_way = WAY_BITS'(w);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    blk_we  = 1'b0;
    blk_way = way_q;
    blk_new = '0;
    lru_en  = 1'b0;
    lru_way = way_q;
    unique case (state_q)
      S_IDLE:     if (cpu_v_i) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (hit) begin
          state_d = S_RESPOND;
          lru_en  = 1'b1;
          lru_way = hit_way;
          blk_way = hit_way;
          blk_we  = req_we_q;
          blk_new = data_q[idx][hit_way];
          blk_new[int'(wsel)*32 +: 32] = req_wdata_q;
        end else if (valid_q[idx][vic_way] && dirty_q[idx][vic_way]) begin
          state_d = S_WB_REQ;
        end else begin
          state_d = S_FILL_REQ;
        end
      end
      S_WB_REQ:   if (mem_ready_i) state_d = S_FILL_REQ;
      S_FILL_REQ: if (mem_ready_i) state_d = S_FILL_WAIT;
      S_FILL_WAIT: begin
        if (mem_v_i) begin
          state_d = S_RESPOND;
          lru_en  = 1'b1;
          blk_we  = 1'b1;
          blk_new = mem_rdata_i;
          if (req_we_q) blk_new[int'(wsel)*32 +: 32] = req_wdata_q;
        end
      end
      S_RESPOND:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      way_q       <= '0;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= WAY_BITS'(w);
        end
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cpu_v_i) begin
        req_we_q    <= cpu_we_i;
        req_addr_q  <= cpu_addr_i[31:2];
        req_wdata_q <= cpu_wdata_i;
      end
      if (state_q == S_LOOKUP) begin
        hit_q <= hit;
        way_q <= hit ? hit_way : vic_way;
        if (hit) begin
          rdata_q <= data_q[idx][hit_way][int'(wsel)*32 +: 32];
          if (req_we_q) dirty_q[idx][hit_way] <= 1'b1;
        end
      end
      if (state_q == S_WB_REQ && mem_ready_i) dirty_q[idx][way_q] <= 1'b0;
      if (state_q == S_FILL_WAIT && mem_v_i) begin
        valid_q[idx][way_q] <= 1'b1;
        dirty_q[idx][way_q] <= req_we_q;
        tag_q[idx][way_q]   <= tag;
        rdata_q             <= blk_new[int'(wsel)*32 +: 32];
      end
      if (lru_en) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          if (WAY_BITS'(w) == lru_way) age_q[idx][w] <= '0;
          else if (age_q[idx][w] < age_q[idx][lru_way]) age_q[idx][w] <= age_q[idx][w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (blk_we) data_q[idx][blk_way] <= blk_new;
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == S_WB_REQ) begin
      mem_addr_o  = {tag_q[idx][way_q], idx, {OFFSET_BITS{1'b0}}};
      mem_wdata_o = data_q[idx][way_q];
    end else if (state_q == S_FILL_REQ) begin
      mem_addr_o  = {tag, idx, {OFFSET_BITS{1'b0}}};
    end
  end

  assign cpu_ready_o = (state_q == S_IDLE);
  assign cpu_v_o     = (state_q == S_RESPOND);
  assign cpu_hit_o   = (state_q == S_RESPOND) && hit_q;
  assign cpu_rdata_o = rdata_q;
  assign mem_v_o     = (state_q == S_WB_REQ) || (state_q == S_FILL_REQ);
  assign mem_we_o    = (state_q == S_WB_REQ);
endmodule

// File: doc/set_assoc_wb_cache.md
Name: set_assoc_wb_cache

Overview:
Parameterised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement and a miss-handling FSM.
Sits between a core's 32-bit load/store port and a block-wide main-memory port; both sides use valid/ready handshakes.
Successor to the fixed 2-way DFF cache: adds configurable associativity, dirty-victim writeback, memory refill and a request/response protocol.

Parameters:
BLOCK_SIZE, 256, bits per block; power of 2, >= 64.
NUM_BLOCKS, 16, total blocks; NUM_SETS = NUM_BLOCKS/NUM_WAYS, power of 2, >= 2.
NUM_WAYS, 2, associativity; power of 2, >= 2.
Derived (localparam): OFFSET_BITS = log2(BLOCK_SIZE/8); INDEX_BITS = log2(NUM_SETS); TAG_BITS = 32-OFFSET_BITS-INDEX_BITS; WORDS = BLOCK_SIZE/32.

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous, active-high reset
cpu_v_i  in  1  core request valid
cpu_we_i  in  1  1 = store word, 0 = load word
cpu_addr_i  in  32  byte address; bits [1:0] ignored
cpu_wdata_i  in  32  store data
cpu_ready_o  out  1  cache can accept a request (high only in IDLE)
cpu_v_o  out  1  one-cycle response pulse (loads and stores)
cpu_rdata_o  out  32  load data, valid while cpu_v_o=1
cpu_hit_o  out  1  qualifies cpu_v_o: 1 = hit, 0 = serviced after miss
mem_v_o  out  1  memory request valid
mem_we_o  out  1  1 = block writeback, 0 = block fetch
mem_addr_o  out  32  block-aligned address (offset bits zero)
mem_wdata_o  out  BLOCK_SIZE  writeback data
mem_ready_i  in  1  memory accepts request
mem_v_i  in  1  fetch data valid (single beat)
mem_rdata_i  in  BLOCK_SIZE  fetched block

Behaviour:
- Reset (async): FSM=IDLE; all valid/dirty=0; age[s][w]=w; cpu_ready_o=1; cpu_v_o, cpu_hit_o, mem_v_o, mem_we_o=0; cpu_rdata_o, mem_addr_o, mem_wdata_o=0. Reset mid-miss abandons the transaction; no writeback.
- Request registered when cpu_v_i & cpu_ready_o. Word select = addr[OFFSET_BITS-1:2]; index = addr[OFFSET_BITS +: INDEX_BITS]; tag = addr[31 -: TAG_BITS].
- States: IDLE -> LOOKUP (accept) -> hit: RESPOND; miss with dirty victim: WB_REQ -> FILL_REQ; miss with clean/invalid victim: FILL_REQ. FILL_REQ -> FILL_WAIT (mem handshake) -> RESPOND (mem_v_i). RESPOND -> IDLE.
- Hit latency: cpu_v_o asserted exactly 2 cycles after the accept edge (LOOKUP, then RESPOND). Next request accepted the cycle after cpu_v_o.
- Multiple tag matches in one set cannot occur (invariant; bench asserts).
- WB_REQ: mem_v_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 0}, mem_wdata_o=victim data; held stable until mem_ready_i; then victim dirty cleared.
- FILL_REQ: mem_v_o=1, mem_we_o=0, mem_addr_o={req tag, index, 0}; held until mem_ready_i. mem_v_i ignored outside FILL_WAIT.
- Fill: victim way <= mem_rdata_i, tag, valid=1, dirty=0; a store then merges its word and sets dirty=1 in the same cycle.
- Store hit: selected word written, dirty=1. Load: cpu_rdata_o = selected word (post-fill data on a miss).
- Victim: lowest-index invalid way; else the way with age NUM_WAYS-1.
- LRU update on every hit or fill to way w with age a: ways with age < a increment; age[w]=0. Ages in a set always form a permutation of 0..NUM_WAYS-1.
- cpu_v_i while busy: ignored; requester must hold until cpu_ready_o.

Test Plan:
- Reset, load 0x040 (defaults: 8 sets, index 2) -> miss: fetch at 0x040, return block word0=0xA5A5_0001 -> cpu_v_o, cpu_hit_o=0, rdata 0xA5A5_0001.
- Repeat load 0x040 -> cpu_v_o 2 cycles after accept, cpu_hit_o=1, no mem_v_o.
- Store 0xDEAD_BEEF to 0x044 (hit), load 0x044 -> 0xDEAD_BEEF, hit; no memory traffic.
- Fill 0x140, then load 0x240 (same set, 0x040 dirty & LRU) -> writeback mem_addr_o=0x040 with word1=0xDEAD_BEEF, then fetch 0x240.
- Stall mem_ready_i low 5 cycles in WB_REQ/FILL_REQ -> mem_v_o/addr/wdata stable, cpu_ready_o=0 throughout.
- Assert reset_i during FILL_WAIT -> outputs immediately at reset values; subsequent load 0x040 misses.
